// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

  localparam int SAR_WIDTH = 4;
  localparam int SAR_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sar_state_e;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation controller: drives a comparator's trial operand and
// recovers the unknown target one bit per step, MSB first.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH  = SAR_WIDTH,
  parameter int SETTLE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_cmp_gt,
  output logic [WIDTH-1:0] o_trial,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
  localparam logic [IDX_W-1:0]     IDX_TOP  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [SAR_CNT_W-1:0] CNT_LOAD = SAR_CNT_W'(SETTLE);
  localparam logic [SAR_CNT_W-1:0] CNT_ONE  = SAR_CNT_W'(1);
  localparam sar_state_e           STEP_ST  = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

  sar_state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_cand, w_cand_nxt, w_cand_upd;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [SAR_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]     r_result, w_result_nxt;
  logic [WIDTH-1:0]     w_bit;
  logic [WIDTH-1:0]     w_trial;

  // Probe value is one below the candidate-with-bit, so cmp_gt means target >= cand|bit.
  assign w_bit   = ONE_W << r_idx;
  assign w_trial = (r_cand | w_bit) - ONE_W;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cand   <= '0;
      r_idx    <= IDX_TOP;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cand   <= w_cand_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    if (i_cmp_gt) begin
      w_cand_upd = r_cand | w_bit;
    end else begin
      w_cand_upd = r_cand;
    end
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_cand_nxt  = '0;
          w_idx_nxt   = IDX_TOP;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = STEP_ST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        w_cand_nxt = w_cand_upd;
        if (r_idx == '0) begin
          w_result_nxt = w_cand_upd;
          w_state_nxt  = ST_DONE;
        end else begin
          w_idx_nxt   = r_idx - IDX_ONE;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = STEP_ST;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the state register
  always_comb begin
    o_trial  = '0;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    o_result = r_result;
    case (r_state)
      ST_SETTLE, ST_SAMPLE: begin
        o_trial = w_trial;
        o_busy  = 1'b1;
      end
      ST_DONE: begin
        o_done = 1'b1;
      end
      default: begin
        o_trial = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench: three controllers (SETTLE 0, 2, 3) each paired with a delayed comparator model.
module tb_sar_search;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   start_s;
  logic [2:0]   cmp_gt_s;
  logic [2:0]   busy_s;
  logic [2:0]   done_s;
  logic [W-1:0] target_s [3];
  logic [W-1:0] trial_s  [3];
  logic [W-1:0] result_s [3];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int lane;
    int res;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int st_of(int g);
    return (g == 0) ? 0 : ((g == 1) ? 2 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int ST = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    logic        cur;
    logic [15:0] hist = '0;
    assign cur = (target_s[g] > trial_s[g]);
    always @(posedge clk) hist <= {hist[14:0], cur};
    if (ST == 0) begin : g_fast
      assign cmp_gt_s[g] = cur;
    end else begin : g_slow
      assign cmp_gt_s[g] = hist[ST-1];
    end
    sar_search #(.WIDTH(W), .SETTLE(ST)) u_dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start_s[g]),
      .i_cmp_gt(cmp_gt_s[g]),
      .o_trial (trial_s[g]),
      .o_busy  (busy_s[g]),
      .o_done  (done_s[g]),
      .o_result(result_s[g])
    );
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (done_s[g]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", g, -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_lane", g, e.lane);
          chk("result", int'(result_s[g]), e.res);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // One search on lane g; start is re-asserted at relative cycles poke1/poke2.
  task automatic do_search(int g, int tgt, int poke1, int poke2);
    int st, c0, r, cand, expt;
    exp_t e;
    st = st_of(g);
    @(negedge clk);
    target_s[g] = W'(tgt);
    start_s[g]  = 1'b1;
    c0 = cyc;
    e.lane = g;
    e.res  = tgt;
    e.cyc  = c0 + W * (st + 1) + 1;
    exp_q.push_back(e);
    for (int k = 0; k < W; k++) begin
      cand = (tgt >> (W - k)) << (W - k);
      expt = cand + (1 << (W - 1 - k)) - 1;
      for (int j = 0; j <= st; j++) begin
        @(negedge clk);
        r = cyc - c0;
        start_s[g] = (r == poke1) || (r == poke2);
        chk("trial", int'(trial_s[g]), expt);
        chk("busy", int'(busy_s[g]), 1);
      end
    end
    @(negedge clk);
    r = cyc - c0;
    start_s[g] = (r == poke1) || (r == poke2);
    chk("busy_at_done", int'(busy_s[g]), 0);
  endtask

  task automatic abort_search(int tgt);
    @(negedge clk);
    target_s[0] = W'(tgt);
    start_s[0]  = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_abort", int'(busy_s[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_trial", int'(trial_s[0]), 0);
    chk("abort_busy", int'(busy_s[0]), 0);
    chk("abort_done", int'(done_s[0]), 0);
    chk("abort_result", int'(result_s[0]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, tgt, p;
    rst     = 1'b1;
    start_s = '0;
    for (int i = 0; i < 3; i++) target_s[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_trial", int'(trial_s[i]), 0);
      chk("rst_busy", int'(busy_s[i]), 0);
      chk("rst_done", int'(done_s[i]), 0);
      chk("rst_result", int'(result_s[i]), 0);
    end

    do_search(0, 11, -1, -1);
    do_search(0, 0, -1, -1);
    do_search(0, 15, -1, -1);
    do_search(1, 6, -1, -1);

    do_search(0, 9, 2, 5);
    do_search(0, 3, -1, -1);

    do_search(0, 5, -1, -1);
    abort_search(13);
    do_search(0, 13, -1, -1);

    for (int t = 0; t < 16; t++) do_search(0, t, -1, -1);
    for (int t = 0; t < 16; t++) do_search(2, t, -1, -1);

    for (int i = 0; i < 30; i++) begin
      g   = int'($urandom_range(0, 2));
      tgt = int'($urandom_range(0, 15));
      p   = int'($urandom_range(1, W * (st_of(g) + 1)));
      do_search(g, tgt, p, -1);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
